// File: rtl/sc_speed_accel_ctrl.sv
// sc_speed_accel_ctrl
// Upstream controller for the player speed counter. Turns the debounced
// accelerator button into periodic one-cycle increment strobes, caps the
// speed at MAX_SPEED using the counter value fed back to it, and holds the
// counter clear line low for a fixed time after a collision.
module sc_speed_accel_ctrl #(
  parameter int DATAWIDTH    = 24,
  parameter int MAX_SPEED    = 200,
  parameter int ACCEL_PERIOD = 2_500_000,
  parameter int PRESCWIDTH   = 22,
  parameter int CRASH_CYCLES = 50_000_000,
  parameter int HOLDWIDTH    = 26
) (
  input  logic                 SC_upSPEEDCOUNTER_CLOCK_50,
  input  logic                 SC_upSPEEDCOUNTER_RESET_InHigh,
  input  logic                 accel_InLow,
  input  logic                 crash_InHigh,
  input  logic [DATAWIDTH-1:0] speed_InBUS,
  output logic                 upcount_OutLow,
  output logic                 T0_OutLow,
  output logic [1:0]           state_OutBUS
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCEL  = 2'b01,
    ST_MAXSPD = 2'b10,
    ST_CRASH  = 2'b11
  } state_t;

  localparam logic [DATAWIDTH-1:0]  MAX_VAL    = DATAWIDTH'(MAX_SPEED);
  localparam logic [PRESCWIDTH-1:0] PRESC_LAST = PRESCWIDTH'(ACCEL_PERIOD - 1);
  localparam logic [HOLDWIDTH-1:0]  HOLD_LAST  = HOLDWIDTH'(CRASH_CYCLES - 1);

  state_t                state_q, state_d;
  logic [PRESCWIDTH-1:0] presc_q, presc_d;
  logic [HOLDWIDTH-1:0]  hold_q, hold_d;
  logic                  upcount_q, upcount_d;
  logic                  t0_q, t0_d;
  logic                  below_max;

  // Anything at or above the cap (including out-of-range values) counts as at-max.
  assign below_max = (speed_InBUS < MAX_VAL);

  // Next state, prescaler and crash hold: crash beats button release beats speed compare.
  always_comb begin
    state_d = state_q;
    presc_d = '0;
    hold_d  = '0;
    if (crash_InHigh) begin
      state_d = ST_CRASH;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!accel_InLow) begin
            state_d = below_max ? ST_ACCEL : ST_MAXSPD;
          end
        end
        ST_ACCEL: begin
          if (accel_InLow) begin
            state_d = ST_IDLE;
          end else if (!below_max) begin
            state_d = ST_MAXSPD;
          end else begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESCWIDTH'(1);
          end
        end
        ST_MAXSPD: begin
          if (accel_InLow) begin
            state_d = ST_IDLE;
          end else if (below_max) begin
            state_d = ST_ACCEL;
          end
        end
        ST_CRASH: begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_IDLE;
          end else begin
            hold_d = hold_q + HOLDWIDTH'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output values for the next cycle; a crash suppresses the strobe so clear always wins.
  always_comb begin
    upcount_d = 1'b1;
    if (!crash_InHigh && (state_q == ST_ACCEL) && (presc_q == PRESC_LAST) && below_max) begin
      upcount_d = 1'b0;
    end
    t0_d = (state_d != ST_CRASH);
  end

  // All state and outputs registered; reset aborts any crash or acceleration at once.
  always_ff @(posedge SC_upSPEEDCOUNTER_CLOCK_50 or posedge SC_upSPEEDCOUNTER_RESET_InHigh) begin
    if (SC_upSPEEDCOUNTER_RESET_InHigh) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      hold_q    <= '0;
      upcount_q <= 1'b1;
      t0_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      hold_q    <= hold_d;
      upcount_q <= upcount_d;
      t0_q      <= t0_d;
    end
  end

  assign upcount_OutLow = upcount_q;
  assign T0_OutLow      = t0_q;
  assign state_OutBUS   = state_q;

endmodule

// File: tb/tb_sc_speed_accel_ctrl.sv
// Testbench for sc_speed_accel_ctrl with a small speed-counter model in the loop,
// a table of directed vectors, hand-written corner sequences and a randomized run
// compared against a behavioural model.
module tb_sc_speed_accel_ctrl;

   localparam int DW     = 8;
   localparam int MAXS   = 3;
   localparam int PER    = 4;
   localparam int CRASHC = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          accelN = 1'b1;
   logic          crash = 1'b0;
   logic [DW-1:0] spdDrv = '0;
   logic [DW-1:0] ctrQ;
   logic [DW-1:0] speedBus;
   logic          useCounter = 1'b0;
   logic          upN;
   logic          t0N;
   logic [1:0]    stateBus;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       accelN;
      logic       crash;
      logic [7:0] spd;
      logic [1:0] expState;
      logic       expUp;
      logic       expT0;
   } vec_t;

   vec_t vecs[$];

   // Behavioural reference: mode 0 idle, 1 accelerating, 2 capped, 3 crashed.
   int   mMode = 0;
   int   mAge = 0;
   int   mLeft = 0;
   logic mUp = 1'b1;
   logic mT0 = 1'b1;

   always #10 clk = ~clk;

   assign speedBus = useCounter ? ctrQ : spdDrv;

   sc_speed_accel_ctrl #(
      .DATAWIDTH(DW), .MAX_SPEED(MAXS), .ACCEL_PERIOD(PER), .PRESCWIDTH(3),
      .CRASH_CYCLES(CRASHC), .HOLDWIDTH(3)
   ) dut (
      .SC_upSPEEDCOUNTER_CLOCK_50(clk),
      .SC_upSPEEDCOUNTER_RESET_InHigh(rst),
      .accel_InLow(accelN),
      .crash_InHigh(crash),
      .speed_InBUS(speedBus),
      .upcount_OutLow(upN),
      .T0_OutLow(t0N),
      .state_OutBUS(stateBus)
   );

   // Speed counter model: increment has priority over clear, as in the real counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ctrQ <= '0;
      else if (!upN) ctrQ <= ctrQ + 8'd1;
      else if (!t0N) ctrQ <= '0;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic a, input logic c, input logic [7:0] s);
      accelN = a;
      crash  = c;
      spdDrv = s;
      @(posedge clk);
      #1;
   endtask

   task automatic addVec(input logic a, input logic c, input logic [7:0] s,
                         input logic [1:0] st, input logic up, input logic t0);
      vec_t v;
      v.accelN = a; v.crash = c; v.spd = s;
      v.expState = st; v.expUp = up; v.expT0 = t0;
      vecs.push_back(v);
   endtask

   task automatic doReset();
      rst = 1'b1;
      accelN = 1'b1;
      crash = 1'b0;
      spdDrv = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      mMode = 0; mAge = 0; mLeft = 0; mUp = 1'b1; mT0 = 1'b1;
   endtask

   // Advance the reference by one clock edge using the inputs present before that edge.
   task automatic modelStep(input logic a, input logic c, input int s);
      bit below;
      int nxt;
      below = (s < MAXS);
      nxt = mMode;
      mUp = 1'b1;
      if (c) begin
         nxt = 3;
         mLeft = CRASHC;
         mAge = 0;
      end else begin
         case (mMode)
            0: begin
               if (!a) nxt = below ? 1 : 2;
               mAge = 0;
            end
            1: begin
               if ((mAge % PER) == PER - 1 && below) mUp = 1'b0;
               if (a) nxt = 0;
               else if (!below) nxt = 2;
               mAge = (nxt == 1) ? mAge + 1 : 0;
            end
            2: begin
               if (a) nxt = 0;
               else if (below) nxt = 1;
               mAge = 0;
            end
            default: begin
               if (mLeft == 1) nxt = 0;
               else mLeft--;
            end
         endcase
      end
      mMode = nxt;
      mT0 = (nxt != 3);
   endtask

   initial begin
      int strobeEdges[$];
      vec_t v;
      logic a;
      logic c;
      int s;

      $display("[TB] start");

      // Reset state, held idle for several cycles.
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 8'd0);
         checkOutput($sformatf("idle%0d state", i), stateBus, 0);
         checkOutput($sformatf("idle%0d up", i), upN, 1);
         checkOutput($sformatf("idle%0d t0", i), t0N, 1);
      end

      // Directed table: {accelN, crash, speed} -> {state, upcount, T0} after the edge.
      addVec(1,0,0, 0,1,1);
      addVec(0,0,0, 1,1,1);
      addVec(0,0,0, 1,1,1);
      addVec(0,0,0, 1,1,1);
      addVec(0,0,0, 1,1,1);
      addVec(0,0,0, 1,0,1);
      addVec(0,0,0, 1,1,1);
      addVec(0,0,3, 2,1,1);
      addVec(0,0,7, 2,1,1);
      addVec(0,0,2, 1,1,1);
      addVec(1,0,2, 0,1,1);
      addVec(0,0,2, 1,1,1);
      addVec(0,0,2, 1,1,1);
      addVec(0,0,2, 1,1,1);
      addVec(0,0,2, 1,1,1);
      addVec(0,0,2, 1,0,1);
      addVec(1,0,5, 0,1,1);
      addVec(0,0,5, 2,1,1);
      addVec(1,0,5, 0,1,1);
      addVec(1,1,0, 3,1,0);
      for (int i = 0; i < 4; i++) addVec(0,0,0, 3,1,0);
      addVec(0,0,0, 0,1,1);
      addVec(0,0,0, 1,1,1);
      addVec(0,0,0, 1,1,1);
      addVec(0,0,0, 1,1,1);
      addVec(0,0,0, 1,1,1);
      addVec(0,1,0, 3,1,0);
      addVec(1,0,0, 3,1,0);
      addVec(1,1,0, 3,1,0);
      for (int i = 0; i < 4; i++) addVec(1,0,0, 3,1,0);
      addVec(1,0,0, 0,1,1);
      addVec(0,0,5, 2,1,1);
      addVec(1,1,5, 3,1,0);
      for (int i = 0; i < 4; i++) addVec(1,0,5, 3,1,0);
      addVec(1,0,5, 0,1,1);

      doReset();
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         applyStimulus(v.accelN, v.crash, v.spd);
         checkOutput($sformatf("vec%0d state", i), stateBus, v.expState);
         checkOutput($sformatf("vec%0d up", i), upN, v.expUp);
         checkOutput($sformatf("vec%0d t0", i), t0N, v.expT0);
      end

      // Counter in the loop: button held from reset, strobes every PER edges until capped.
      doReset();
      useCounter = 1'b1;
      for (int e = 1; e <= 24; e++) begin
         applyStimulus(1'b0, 1'b0, 8'd0);
         if (!upN) strobeEdges.push_back(e);
         if (!upN && !t0N) checkOutput("loop both low", 1, 0);
      end
      checkOutput("loop strobe count", strobeEdges.size(), 3);
      for (int k = 0; k < strobeEdges.size() && k < 3; k++)
         checkOutput($sformatf("loop strobe%0d edge", k), strobeEdges[k], 5 + PER * k);
      checkOutput("loop speed", ctrQ, 3);
      checkOutput("loop state", stateBus, 2);

      // One-cycle crash pulse at top speed with the button still held.
      applyStimulus(1'b0, 1'b1, 8'd0);
      checkOutput("crash entry state", stateBus, 3);
      checkOutput("crash entry t0", t0N, 0);
      for (int k = 1; k < CRASHC; k++) begin
         applyStimulus(1'b0, 1'b0, 8'd0);
         checkOutput($sformatf("crash hold%0d t0", k), t0N, 0);
         checkOutput($sformatf("crash hold%0d up", k), upN, 1);
      end
      checkOutput("crash speed cleared", ctrQ, 0);
      applyStimulus(1'b0, 1'b0, 8'd0);
      checkOutput("crash exit state", stateBus, 0);
      checkOutput("crash exit t0", t0N, 1);
      applyStimulus(1'b0, 1'b0, 8'd0);
      checkOutput("crash reaccel state", stateBus, 1);
      useCounter = 1'b0;

      // Asynchronous reset in the middle of a crash.
      doReset();
      applyStimulus(1'b1, 1'b1, 8'd0);
      checkOutput("pre-areset crash t0", t0N, 0);
      crash = 1'b0;
      #3 rst = 1'b1;
      #2;
      checkOutput("areset crash state", stateBus, 0);
      checkOutput("areset crash t0", t0N, 1);

      // Asynchronous reset while a strobe is on the output.
      doReset();
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 8'd0);
      checkOutput("pre-areset strobe", upN, 0);
      #3 rst = 1'b1;
      #2;
      checkOutput("areset accel state", stateBus, 0);
      checkOutput("areset accel up", upN, 1);

      // Randomized run against the behavioural model.
      doReset();
      a = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) a = ~a;
         c = ($urandom_range(0, 29) == 0);
         s = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 255);
         modelStep(a, c, s);
         applyStimulus(a, c, 8'(s));
         checkOutput($sformatf("rand%0d state", i), stateBus, mMode);
         checkOutput($sformatf("rand%0d up", i), upN, mUp);
         checkOutput($sformatf("rand%0d t0", i), t0N, mT0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
